// File: rtl/mul_div_unit.sv
// mul_div_unit: 32-bit iterative multiply/divide unit with HI/LO registers.
// Fixed 34-cycle latency: PREP, 32 radix-2 RUN steps, FIX sign correction.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        wr_hi_i,
    input  logic        wr_lo_i,
    input  logic [31:0] wr_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        signed_op;
    logic [31:0] mag_a, mag_b, quo, rem;
    logic [32:0] msum, r_sh, diff;
    logic [63:0] step, prod;

    // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div
    always_comb begin
        signed_op = !op_q[0];
        mag_a = (signed_op && a_q[31]) ? -a_q : a_q;
        mag_b = (signed_op && b_q[31]) ? -b_q : b_q;
        msum = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? m_q : 32'd0};
        r_sh = acc_q[63:31];
        diff = r_sh - {1'b0, m_q};
        step = !op_q[1] ? {msum, acc_q[31:1]} :
               diff[32] ? {r_sh[31:0], acc_q[30:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
        prod = neg_q ? -acc_q : acc_q;
        quo = neg_q ? -acc_q[31:0] : acc_q[31:0];
        rem = rneg_q ? -acc_q[63:32] : acc_q[63:32];
    end

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        a_d = a_q;
        b_d = b_q;
        m_d = m_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
        rneg_d = rneg_q;
        done_d = 1'b0;
        hi_d = hi_q;
        lo_d = lo_q;
        case (state_q)
            IDLE: begin
                hi_d = wr_hi_i ? wr_data_i : hi_q;
                lo_d = wr_lo_i ? wr_data_i : lo_q;
                if (start_i) begin
                    state_d = PREP;
                    op_d = op_i;
                    a_d = a_i;
                    b_d = b_i;
                end
            end
            PREP: begin
                m_d = op_q[1] ? mag_b : mag_a;
                acc_d = {32'd0, op_q[1] ? mag_a : mag_b};
                neg_d = signed_op & (a_q[31] ^ b_q[31]);
                rneg_d = signed_op & a_q[31];
                cnt_d = 5'd0;
                state_d = RUN;
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd31) ? FIX : RUN;
            end
            FIX: begin
                state_d = IDLE;
                done_d = 1'b1;
                hi_d = !op_q[1] ? prod[63:32] : (b_q == 32'd0) ? a_q : rem;
                lo_d = !op_q[1] ? prod[31:0] : (b_q == 32'd0) ? 32'hFFFF_FFFF : quo;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q <= 2'd0;
            a_q <= 32'd0;
            b_q <= 32'd0;
            m_q <= 32'd0;
            acc_q <= 64'd0;
            cnt_q <= 5'd0;
            neg_q <= 1'b0;
            rneg_q <= 1'b0;
            done_q <= 1'b0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            a_q <= a_d;
            b_q <= b_d;
            m_q <= m_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            neg_q <= neg_d;
            rneg_q <= rneg_d;
            done_q <= done_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven and scoreboarded bench for mul_div_unit.
module tb_mul_div_unit;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0, b = 32'd0, wr_data = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .wr_hi_i(wr_hi), .wr_lo_i(wr_lo), .wr_data_i(wr_data),
        .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] cur_hi = 32'd0, cur_lo = 32'd0;

    typedef struct {logic [31:0] hi; logic [31:0] lo; int at;} exp_t;
    typedef struct {logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] hi; logic [31:0] lo;} vec_t;
    exp_t sb[$];
    vec_t vecs[13];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // done must match the oldest outstanding expectation, at its exact cycle
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done high with nothing outstanding (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("latency", 32'(cyc), 32'(e.at));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        logic [63:0] ux = {32'd0, x};
        logic [63:0] uy = {32'd0, y};
        longint q, r;
        logic [63:0] uq, ur;
        if (o[1] && y == 32'd0) return {x, 32'hFFFF_FFFF};
        case (o)
            2'd0: return 64'(sx * sy);
            2'd1: return ux * uy;
            2'd2: begin
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back('{eh, el, cyc + 35});
        cur_hi = eh;
        cur_lo = el;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        logic [63:0] m;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int t;
        vecs[0]  = '{2'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{2'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'd3, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
        vecs[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        vecs[5]  = '{2'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[7]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{2'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
        vecs[9]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[10] = '{2'd0, 32'd0,        32'h12345678, 32'd0,        32'd0};
        vecs[11] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[12] = '{2'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst_n = 1'b1;

        @(negedge clk);
        wr_hi = 1'b1;
        wr_data = 32'h1234;
        @(negedge clk);
        wr_hi = 1'b0;
        wr_lo = 1'b1;
        wr_data = 32'h5678;
        check("mthi_idle", hi, 32'h1234);
        @(negedge clk);
        wr_lo = 1'b0;
        check("mtlo_idle", lo, 32'h5678);

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 6 == 0) ? 32'd0 : (i % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            m = model(ro, ra, rb);
            run_op(ro, ra, rb, m[63:32], m[31:0]);
        end

        // writes while busy are dropped, and hi/lo hold their old values
        @(negedge clk);
        op = 2'd0;
        a = 32'd5;
        b = 32'd6;
        start = 1'b1;
        sb.push_back('{32'd0, 32'd30, cyc + 35});
        @(negedge clk);
        start = 1'b0;
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wr_data = 32'hDEAD;
        @(negedge clk);
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        check("busy_running", 32'(busy), 32'd1);
        check("mthi_busy_ignored", hi, cur_hi);
        check("mtlo_busy_ignored", lo, cur_lo);
        wait_drain();

        // a write coinciding with an accepted start lands, then the result overwrites it
        @(negedge clk);
        op = 2'd3;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        wr_lo = 1'b1;
        wr_data = 32'hCAFE;
        sb.push_back('{32'd2, 32'd14, cyc + 35});
        @(negedge clk);
        start = 1'b0;
        wr_lo = 1'b0;
        check("mtlo_with_start", lo, 32'hCAFE);
        wait_drain();

        // asynchronous reset in the middle of RUN abandons the operation
        @(negedge clk);
        op = 2'd0;
        a = 32'd9;
        b = 32'd9;
        start = 1'b1;
        sb.push_back('{32'd0, 32'd81, cyc + 35});
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        check("async_reset_hi", hi, 32'd0);
        check("async_reset_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(2'd0, 32'd5, 32'd6, 32'd0, 32'd30);

        // start held high: second op accepted 35 cycles after the first
        @(negedge clk);
        op = 2'd1;
        a = 32'd2;
        b = 32'd3;
        start = 1'b1;
        t = cyc + 1;
        sb.push_back('{32'd0, 32'd6, t + 34});
        @(negedge clk);
        op = 2'd2;
        a = 32'd9;
        b = 32'd4;
        sb.push_back('{32'd1, 32'd2, t + 69});
        while (cyc < t + 69) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_outstanding", 32'(sb.size()), 32'd0);
        check("b2b_no_third_op", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
